// File: rtl/led_seq_pkg.sv
// Shared types, rate codes and helpers for the LED rate sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam logic [1:0] RATE_SLOW = 2'd0;
  localparam logic [1:0] RATE_MID  = 2'd1;
  localparam logic [1:0] RATE_FAST = 2'd2;

  // Terminal prescaler count for a 2^tap period; callers cast to their width.
  function automatic logic [31:0] tap_to_last(input int unsigned tap);
    return (32'd1 << tap) - 32'd1;
  endfunction

  function automatic logic [1:0] decode_rate(input logic [2:0] sel);
    case (sel)
      3'b010:  return RATE_MID;
      3'b100:  return RATE_FAST;
      default: return RATE_SLOW;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single decimal digit counter with synchronous clear and a one-cycle wrap pulse.
module bcd_digit_counter #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] q,
  output logic       wrap
);

  localparam logic [3:0] LAST = 4'(MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        q <= '0;
      end else if (enable) begin
        if (q == LAST) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q <= q + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/led_rate_sequencer.sv
// Run/pause/clear sequencer: switch-selected prescaler ticks a decimal digit
// shown on the LEDs.
module led_rate_sequencer #(
  parameter int unsigned PRESC_W   = 30,
  parameter int unsigned TAP_SLOW  = 26,
  parameter int unsigned TAP_MID   = 23,
  parameter int unsigned TAP_FAST  = 20,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       btn_run,
  input  logic       btn_clr,
  output logic [3:0] led,
  output logic       tick,
  output logic       carry,
  output logic       running,
  output logic [1:0] rate
);

  import led_seq_pkg::*;

  localparam logic [PRESC_W-1:0] LAST_SLOW = PRESC_W'(tap_to_last(TAP_SLOW));
  localparam logic [PRESC_W-1:0] LAST_MID  = PRESC_W'(tap_to_last(TAP_MID));
  localparam logic [PRESC_W-1:0] LAST_FAST = PRESC_W'(tap_to_last(TAP_FAST));

  state_t             state, state_nx;
  logic               run_q, clr_q;
  logic               run_edge, clr_edge;
  logic [PRESC_W-1:0] presc, presc_nx, last;
  logic [1:0]         sw_rate, rate_nx;
  logic               fire, digit_clr;

  assign run_edge = btn_run & ~run_q;
  assign clr_edge = btn_clr & ~clr_q;
  assign sw_rate  = decode_rate(sw);
  assign running  = (state == RUN);

  always_comb begin
    case (rate)
      RATE_MID:  last = LAST_MID;
      RATE_FAST: last = LAST_FAST;
      default:   last = LAST_SLOW;
    endcase
  end

  // A pause in the terminal cycle still completes the count; only clear suppresses it.
  assign fire      = (state == RUN) && (presc == last) && !clr_edge;
  assign digit_clr = clr_edge || (state == IDLE);

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    rate_nx  = rate;
    case (state)
      IDLE: begin
        presc_nx = '0;
        rate_nx  = sw_rate;
        if (run_edge) state_nx = RUN;
      end
      RUN: begin
        presc_nx = fire ? '0 : presc + PRESC_W'(1);
        if (fire) rate_nx = sw_rate;
        if (run_edge) state_nx = PAUSE;
      end
      PAUSE: begin
        rate_nx = sw_rate;
        if (run_edge) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
    if (clr_edge) begin
      state_nx = IDLE;
      presc_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      rate  <= RATE_SLOW;
      tick  <= 1'b0;
      run_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      rate  <= rate_nx;
      tick  <= fire;
      run_q <= btn_run;
      clr_q <= btn_clr;
    end
  end

  bcd_digit_counter #(
    .MAX(MAX_DIGIT)
  ) u_digit (
    .clk   (clk),
    .reset (reset),
    .clear (digit_clr),
    .enable(fire),
    .q     (led),
    .wrap  (carry)
  );

endmodule

// File: tb/tb_led_rate_sequencer.sv
// Directed self-checking bench for led_rate_sequencer with periods 16/8/4.
module tb_led_rate_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sw = 3'b001;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] led;
  logic       tick, carry, running;
  logic [1:0] rate;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_rate_sequencer #(
    .PRESC_W  (5),
    .TAP_SLOW (4),
    .TAP_MID  (3),
    .TAP_FAST (2),
    .MAX_DIGIT(9)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .led    (led),
    .tick   (tick),
    .carry  (carry),
    .running(running),
    .rate   (rate)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_run();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
  endtask

  // Steps until tick is seen; n is the number of edges taken (capped).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 64);
  endtask

  initial begin
    int n;
    int seen;

    // 1: reset state, slow rate
    #12;
    chk("rst_led", led, 0);
    chk("rst_tick", tick, 0);
    chk("rst_carry", carry, 0);
    chk("rst_running", running, 0);
    chk("rst_rate", rate, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    press_run();
    chk("t1_running", running, 1);
    wait_tick(n);
    chk("t1_first_tick", n, 16);
    chk("t1_led", led, 1);
    step();
    chk("t1_tick_pulse", tick, 0);
    wait_tick(n);
    chk("t1_second_tick", n, 15);
    chk("t1_led2", led, 2);

    // 2: fast rate, full decade with carry
    press_clr();
    chk("t2_clr_led", led, 0);
    chk("t2_clr_running", running, 0);
    sw = 3'b100;
    step();
    chk("t2_idle_rate", rate, 2);
    press_run();
    for (int i = 1; i <= 10; i++) begin
      wait_tick(n);
      chk("t2_period", n, 4);
      chk("t2_led", led, i % 10);
      chk("t2_carry", carry, (i == 10) ? 1 : 0);
    end
    step();
    chk("t2_carry_clear", carry, 0);
    chk("t2_tick_clear", tick, 0);

    // 3: rate change mid-period applies at the tick
    press_clr();
    sw = 3'b001;
    step();
    press_run();
    repeat (5) step();
    sw = 3'b010;
    step();
    chk("t3_rate_held", rate, 0);
    wait_tick(n);
    chk("t3_tick_at_16", n, 10);
    chk("t3_rate_loaded", rate, 1);
    chk("t3_led", led, 1);
    wait_tick(n);
    chk("t3_mid_period", n, 8);
    chk("t3_led2", led, 2);

    // 4: pause keeps the partial period
    press_clr();
    sw = 3'b001;
    step();
    press_run();
    repeat (5) step();
    press_run();
    chk("t4_paused", running, 0);
    seen = 0;
    sw = 3'b100;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) begin
        chk("t4_pause_rate", rate, 2);
        sw = 3'b001;
      end
      step();
      if (tick) seen++;
    end
    chk("t4_no_ticks", seen, 0);
    chk("t4_led_held", led, 0);
    chk("t4_rate_back", rate, 0);
    press_run();
    chk("t4_resumed", running, 1);
    wait_tick(n);
    chk("t4_resume_tick", n, 10);
    chk("t4_led", led, 1);

    // 5: held run button, clear in the terminal cycle
    press_clr();
    step();
    btn_run = 1'b1;
    step();
    chk("t5_running", running, 1);
    repeat (15) step();
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    chk("t5_tick", tick, 0);
    chk("t5_carry", carry, 0);
    chk("t5_led", led, 0);
    chk("t5_idle", running, 0);
    repeat (3) step();
    chk("t5_held_no_edge", running, 0);
    btn_run = 1'b0;
    step();
    chk("t5_released", running, 0);

    // 6: invalid switch patterns and async reset
    sw = 3'b010;
    step();
    chk("t6_rate_mid", rate, 1);
    sw = 3'b011;
    step();
    chk("t6_rate_011", rate, 0);
    sw = 3'b000;
    step();
    chk("t6_rate_000", rate, 0);
    sw = 3'b011;
    press_run();
    wait_tick(n);
    chk("t6_slow_period", n, 16);
    chk("t6_rate_run", rate, 0);
    sw = 3'b100;
    wait_tick(n);
    chk("t6_second", n, 16);
    chk("t6_rate_fast", rate, 2);
    chk("t6_led_pre", led, 2);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_async_led", led, 0);
    chk("t6_async_running", running, 0);
    chk("t6_async_rate", rate, 0);
    chk("t6_async_tick", tick, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t6_post_reset", running, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_rate_sequencer.md
Name: led_rate_sequencer

Overview:
Run/pause/clear controller for the board's LED rate-divider datapath. A prescaler generates a tick strobe at one of three switch-selected rates, and a decimal digit counter (0–9) advances on each tick to drive the 4 LEDs. The block sits between the switches/push-buttons and the LEDs, and replaces the free-running divider with a sequenced, bounded one.

Parameters:
PRESC_W, 30, prescaler width in bits; must be at least TAP_SLOW+1.
TAP_SLOW, 26, slow rate tick period is 2^TAP_SLOW cycles.
TAP_MID, 23, mid rate tick period is 2^TAP_MID cycles.
TAP_FAST, 20, fast rate tick period is 2^TAP_FAST cycles.
MAX_DIGIT, 9, terminal value of the digit counter.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
sw  in  3  one-hot rate select: 001 slow, 010 mid, 100 fast.
btn_run  in  1  run/pause button, level; already synchronous and debounced upstream.
btn_clr  in  1  clear button, level; already synchronous and debounced upstream.
led  out  4  current digit value, 0..MAX_DIGIT.
tick  out  1  one-cycle pulse, high on each digit advance.
carry  out  1  one-cycle pulse, high on the MAX_DIGIT->0 wrap.
running  out  1  high while in state RUN.
rate  out  2  applied rate: 0 slow, 1 mid, 2 fast.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prescaler=0, digit=0, rate=0, tick=0, carry=0, button history regs=0. All outputs are registered.
- Edge detect: run_edge = btn_run & ~btn_run_q; clr_edge likewise. A held button produces exactly one edge.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE -> RUN on run_edge.
  - RUN -> PAUSE on run_edge.
  - PAUSE -> RUN on run_edge.
  - Any state -> IDLE on clr_edge. clr_edge beats run_edge in the same cycle.
- IDLE: prescaler=0, digit=0.
- PAUSE: prescaler and digit hold their values. Resuming continues the partial period; the period does not restart.
- Rate decode: 001->0, 010->1, 100->2. Any other pattern (000, multi-hot) ->0 (slow).
- Rate apply:
  - In IDLE/PAUSE, rate follows the decoded sw every cycle.
  - In RUN, rate loads only on the edge where the tick fires, so a period is never truncated or stretched mid-way.
- Period P = 2^TAP for the applied rate.
- Prescaler: increments each RUN cycle. When prescaler==P-1 in RUN, on the next edge: prescaler<=0, tick<=1, digit advances.
- Tick timing: the first tick goes high exactly P cycles after the edge that entered RUN.
- Digit: increments by 1 on each tick. When the digit is MAX_DIGIT, it becomes 0 instead and carry<=1 in the same cycle as tick. Values 10–15 never appear on led.
- Tick/carry clear: both deassert on the next edge unless another tick fires (possible only for P=1, which is not supported).
- Simultaneous events: clr_edge in the terminal cycle clears everything, with no tick and no carry. run_edge (pause) in the terminal cycle:
  - the state goes to PAUSE;
  - the tick still fires and the digit advances (the terminal count completes);
  - the prescaler goes to 0.
- running = (state==RUN), registered with the state.
- Reset mid-operation returns all outputs to their reset values immediately (asynchronously).

Decomposition:
- Package led_seq_pkg:
  - state enum IDLE/RUN/PAUSE;
  - rate codes RATE_SLOW=0, RATE_MID=1, RATE_FAST=2;
  - function tap_to_last(tap) returning 2^tap-1 at PRESC_W width.
- One natural sub-module: bcd_digit_counter (enable, clear, q[3:0], wrap pulse), reusable for later multi-digit displays.
- Edge detectors and the FSM stay inline.

Test Plan:
(All with TAP_SLOW=4, TAP_MID=3, TAP_FAST=2, so periods are 16, 8 and 4.)
1. Reset low, release, sw=001, pulse btn_run for 1 cycle -> running=1; first tick 16 cycles after the RUN edge; led 0->1; then a tick every 16 cycles.
2. Run at sw=100 for 40 cycles -> 10 ticks; led goes 1..9 then 0; carry=1 only on the 10th tick, together with tick.
3. Run at sw=001, switch to sw=010 mid-period (prescaler=5) -> the current tick still lands at 16; rate=1 from that tick; the next tick comes 8 cycles later.
4. Run, press btn_run at prescaler=6 (PAUSE), wait 50 cycles, press again -> led unchanged while paused; the next tick comes 10 cycles after resume.
5. Hold btn_run high 20 cycles with btn_clr pulsing in the terminal cycle -> only one run edge; clear wins; led=0, tick=0, carry=0, state IDLE.
6. sw=011 and sw=000 -> rate=0 (slow, period 16); assert reset low mid-RUN -> led=0, running=0, rate=0 without a clock edge.
